// File: rtl/zkbdmus_spirx_if.sv
// SPI receive bus: serial inputs from the AVR plus the deserialised keyboard/mouse outputs.
// master = AVR/consumer side, slave = the receive stage.
interface zkbdmus_spirx_if;
  logic        spics_n;
  logic        spick;
  logic        spido;
  logic [39:0] kbd_out;
  logic        kbd_stb;
  logic [7:0]  mus_out;
  logic        mus_xstb;
  logic        mus_ystb;
  logic        mus_btnstb;
  logic        frm_abort;

  modport master (
    output spics_n, spick, spido,
    input  kbd_out, kbd_stb, mus_out, mus_xstb, mus_ystb, mus_btnstb, frm_abort
  );

  modport slave (
    input  spics_n, spick, spido,
    output kbd_out, kbd_stb, mus_out, mus_xstb, mus_ystb, mus_btnstb, frm_abort
  );
endinterface

// File: rtl/zkbdmus_spirx.sv
// SPI-slave receive stage: deserialises AVR keyboard-matrix and mouse frames in the fclk
// domain and presents them as a 40-bit key vector and a strobed 8-bit mouse bus.
module zkbdmus_spirx #(
  parameter logic [7:0] ADDR_KBD    = 8'h10,
  parameter logic [7:0] ADDR_MUSX   = 8'h40,
  parameter logic [7:0] ADDR_MUSY   = 8'h41,
  parameter logic [7:0] ADDR_MUSBTN = 8'h42
) (
  input  logic             fclk,
  input  logic             rst_n,
  zkbdmus_spirx_if.slave   bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_KBD  = 3'd2;
  localparam logic [2:0] S_MUS  = 3'd3;
  localparam logic [2:0] S_IGN  = 3'd4;

  logic        sck_s1, sck_s2, sck_s3;
  logic        cs_s1, cs_s2, cs_s3;
  logic        mosi_s1, mosi_s2;
  logic        sck_rise, cs_rise;

  logic [7:0]  sh;
  logic [2:0]  bitcnt;
  logic        byte_done;

  logic [2:0]  state;
  logic [2:0]  bytecnt;
  logic [39:0] kbuf;
  logic [1:0]  mus_sel;

  // Chip select idles high, so its chain resets to 1 to avoid a false frame start.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_s3  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= bus.spick;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      cs_s1   <= bus.spics_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      mosi_s1 <= bus.spido;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sck_rise = sck_s2 & ~sck_s3;
  assign cs_rise  = cs_s2 & ~cs_s3;

  // A rise coinciding with CS high is dropped; the bit counter is held at 0 between frames.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      sh        <= 8'h00;
      bitcnt    <= 3'd0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (cs_s2) begin
        bitcnt <= 3'd0;
      end else if (sck_rise) begin
        sh        <= {sh[6:0], mosi_s2};
        bitcnt    <= bitcnt + 3'd1;
        byte_done <= (bitcnt == 3'd7);
      end
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      bytecnt        <= 3'd0;
      kbuf           <= 40'd0;
      mus_sel        <= 2'd0;
      bus.kbd_out    <= 40'd0;
      bus.kbd_stb    <= 1'b0;
      bus.mus_out    <= 8'h00;
      bus.mus_xstb   <= 1'b0;
      bus.mus_ystb   <= 1'b0;
      bus.mus_btnstb <= 1'b0;
      bus.frm_abort  <= 1'b0;
    end else begin
      bus.kbd_stb    <= 1'b0;
      bus.mus_xstb   <= 1'b0;
      bus.mus_ystb   <= 1'b0;
      bus.mus_btnstb <= 1'b0;
      bus.frm_abort  <= 1'b0;
      if (cs_s2) begin
        state   <= S_IDLE;
        bytecnt <= 3'd0;
        // An empty frame (no bits after the command decode point) is a clean end.
        if (cs_rise && ((bitcnt != 3'd0) || (state == S_KBD && bytecnt < 3'd5)))
          bus.frm_abort <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            state   <= S_CMD;
            bytecnt <= 3'd0;
          end
          S_CMD: begin
            if (byte_done) begin
              case (sh)
                ADDR_KBD:    state <= S_KBD;
                ADDR_MUSX:   begin state <= S_MUS; mus_sel <= 2'd0; end
                ADDR_MUSY:   begin state <= S_MUS; mus_sel <= 2'd1; end
                ADDR_MUSBTN: begin state <= S_MUS; mus_sel <= 2'd2; end
                default:     state <= S_IGN;
              endcase
            end
          end
          S_KBD: begin
            if (byte_done) begin
              kbuf    <= {kbuf[31:0], sh};
              bytecnt <= bytecnt + 3'd1;
              if (bytecnt == 3'd4) begin
                bus.kbd_out <= {kbuf[31:0], sh};
                bus.kbd_stb <= 1'b1;
                state       <= S_IGN;
              end
            end
          end
          S_MUS: begin
            if (byte_done) begin
              bus.mus_out    <= sh;
              bus.mus_xstb   <= (mus_sel == 2'd0);
              bus.mus_ystb   <= (mus_sel == 2'd1);
              bus.mus_btnstb <= (mus_sel == 2'd2);
              state          <= S_IGN;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
